// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Merges the write streams of two requesters into the single
//            write port of a 32x64 register file. There is one holding slot
//            per requester. Slots that target different registers alternate
//            round-robin. Slots that target the same register issue oldest
//            first. Register 31 (X31) is hardwired to zero, so a write to it
//            is consumed without asserting RegWrite.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_reg,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_reg,
    input  logic [63:0] req1_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic [31:0] pending
);

    // X31 reads as zero; writes to it must never reach the register file.
    localparam logic [4:0] c_zero_reg = 5'd31;

    // Holding slots, one per requester.
    logic        r_slot0_valid;
    logic [4:0]  r_slot0_reg;
    logic [63:0] r_slot0_data;
    logic        r_slot1_valid;
    logic [4:0]  r_slot1_reg;
    logic [63:0] r_slot1_data;

    // Round-robin pointer: 0 = requester 0 wins the next different-register tie.
    logic        r_rr;
    // Age bit: 1 = slot 0 holds the older write.
    logic        r_older0;

    // Registered output stage.
    logic        r_regwrite;
    logic [4:0]  r_write_reg;
    logic [63:0] r_write_data;

    // Arbitration results.
    logic        w_both;
    logic        w_same_reg;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_issue;
    logic [4:0]  w_issue_reg;
    logic [63:0] w_issue_data;
    logic        w_load0;
    logic        w_load1;

    // Pick at most one valid slot: a lone slot wins; same register goes by age;
    // different registers go by the round-robin pointer.
    always_comb begin
        w_both     = r_slot0_valid & r_slot1_valid;
        w_same_reg = w_both & (r_slot0_reg == r_slot1_reg);
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        if (r_slot0_valid && !r_slot1_valid) begin
            w_grant0 = 1'b1;
        end else if (!r_slot0_valid && r_slot1_valid) begin
            w_grant1 = 1'b1;
        end else if (w_both) begin
            if (w_same_reg) begin
                w_grant0 = r_older0;
                w_grant1 = ~r_older0;
            end else begin
                w_grant0 = ~r_rr;
                w_grant1 = r_rr;
            end
        end
    end

    // Select the granted slot's contents for the output stage.
    always_comb begin
        w_issue      = w_grant0 | w_grant1;
        w_issue_reg  = r_slot0_reg;
        w_issue_data = r_slot0_data;
        if (w_grant1) begin
            w_issue_reg  = r_slot1_reg;
            w_issue_data = r_slot1_data;
        end
    end

    // A slot can accept when empty or when it is being drained this cycle.
    assign req0_ready = ~r_slot0_valid | w_grant0;
    assign req1_ready = ~r_slot1_valid | w_grant1;
    assign w_load0    = req0_valid & req0_ready;
    assign w_load1    = req1_valid & req1_ready;

    // Slot 0: reload takes precedence over clearing on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot0_valid <= 1'b0;
            r_slot0_reg   <= 5'd0;
            r_slot0_data  <= 64'd0;
        end else if (w_load0) begin
            r_slot0_valid <= 1'b1;
            r_slot0_reg   <= req0_reg;
            r_slot0_data  <= req0_data;
        end else if (w_grant0) begin
            r_slot0_valid <= 1'b0;
        end
    end

    // Slot 1: reload takes precedence over clearing on grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot1_valid <= 1'b0;
            r_slot1_reg   <= 5'd0;
            r_slot1_data  <= 64'd0;
        end else if (w_load1) begin
            r_slot1_valid <= 1'b1;
            r_slot1_reg   <= req1_reg;
            r_slot1_data  <= req1_data;
        end else if (w_grant1) begin
            r_slot1_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves only when it actually decided a contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_both && !w_same_reg) begin
            r_rr <= w_grant0;
        end
    end

    // Age tracking: a slot loaded while the other keeps its entry is younger;
    // simultaneous loads make requester 0 the older one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_older0 <= 1'b1;
        end else if (w_load0 && w_load1) begin
            r_older0 <= 1'b1;
        end else if (w_load0 && r_slot1_valid && !w_grant1) begin
            r_older0 <= 1'b0;
        end else if (w_load1 && r_slot0_valid && !w_grant0) begin
            r_older0 <= 1'b1;
        end
    end

    // Output stage: copy the granted slot; X31 consumes the grant silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite   <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 64'd0;
        end else if (w_issue) begin
            r_regwrite   <= (w_issue_reg != c_zero_reg);
            r_write_reg  <= w_issue_reg;
            r_write_data <= w_issue_data;
        end else begin
            r_regwrite   <= 1'b0;
        end
    end

    assign RegWrite      = r_regwrite;
    assign WriteRegister = r_write_reg;
    assign WriteData     = r_write_data;

    // Scoreboard bits for hazard detection: a register is pending while it
    // sits in either slot or in the output stage with its enable asserted.
    for (genvar r = 0; r < 31; r++) begin : g_pending
        assign pending[r] = (r_slot0_valid && (r_slot0_reg == 5'(r))) ||
                            (r_slot1_valid && (r_slot1_reg == 5'(r))) ||
                            (r_regwrite    && (r_write_reg == 5'(r)));
    end
    assign pending[31] = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter: fixed vector
//            table, directed corner sequences and random traffic compared
//            against a slot/sequence-number reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_reg, req1_reg;
    logic [63:0] req0_data, req1_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_reg      (req0_reg),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_reg      (req1_reg),
        .req1_data     (req1_data),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .pending       (pending)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each held write carries the sequence number of the edge it was accepted
    // on; a smaller number is older, equal numbers favour requester 0.
    typedef struct {
        logic        v;
        logic [4:0]  rg;
        logic [63:0] d;
        int unsigned seq;
    } slot_t;

    slot_t       ms[2];
    logic        mrr;
    int unsigned mseq;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) ms[i] = '{1'b0, 5'd0, 64'd0, 0};
        mrr  = 1'b0;
        mseq = 0;
        m_rw = 1'b0;
        m_wr = 5'd0;
        m_wd = 64'd0;
    endtask

    function automatic int mgrant();
        if (!ms[0].v && !ms[1].v) return -1;
        if (ms[0].v && !ms[1].v) return 0;
        if (!ms[0].v && ms[1].v) return 1;
        if (ms[0].rg == ms[1].rg) return (ms[1].seq < ms[0].seq) ? 1 : 0;
        return mrr ? 1 : 0;
    endfunction

    function automatic logic [31:0] mpend();
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < 2; i++) if (ms[i].v) p[ms[i].rg] = 1'b1;
        if (m_rw) p[m_wr] = 1'b1;
        p[31] = 1'b0;
        return p;
    endfunction

    // One clock cycle with the currently driven inputs; checks ready before
    // the edge and the registered outputs after it.
    task automatic step(output logic acc0, output logic acc1);
        int          g;
        logic [4:0]  r0, r1;
        logic [63:0] d0, d1;
        #1;
        g = mgrant();
        chk("ready0", req0_ready, (!ms[0].v || g == 0));
        chk("ready1", req1_ready, (!ms[1].v || g == 1));
        acc0 = req0_valid && (!ms[0].v || g == 0);
        acc1 = req1_valid && (!ms[1].v || g == 1);
        r0 = req0_reg; d0 = req0_data;
        r1 = req1_reg; d1 = req1_data;
        @(posedge clk);
        #1;
        mseq++;
        if (g >= 0) begin
            m_wr = ms[g].rg;
            m_wd = ms[g].d;
            m_rw = (ms[g].rg != 5'd31);
            if (ms[0].v && ms[1].v && ms[0].rg != ms[1].rg) mrr = (g == 0);
            ms[g].v = 1'b0;
        end else begin
            m_rw = 1'b0;
        end
        if (acc0) ms[0] = '{1'b1, r0, d0, mseq};
        if (acc1) ms[1] = '{1'b1, r1, d1, mseq};
        chk("regwrite", RegWrite, m_rw);
        chk("write_reg", WriteRegister, m_wr);
        chk("write_data", WriteData, m_wd);
        chk("pending", pending, mpend());
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_reg = 5'd0; req0_data = 64'd0;
        req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 64'd0;
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        chk("rst_regwrite", RegWrite, 1'b0);
        chk("rst_write_reg", WriteRegister, 5'd0);
        chk("rst_write_data", WriteData, 64'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_ready0", req0_ready, 1'b1);
        chk("rst_ready1", req1_ready, 1'b1);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [63:0] d1;
        logic        er0;
        logic        er1;
        logic        erw;
        logic [4:0]  ewr;
        logic [63:0] ewd;
        logic [31:0] epend;
    } vec_t;

    function automatic vec_t mkv(
        input logic v0, input logic [4:0] r0, input logic [63:0] d0,
        input logic v1, input logic [4:0] r1, input logic [63:0] d1,
        input logic er0, input logic er1, input logic erw,
        input logic [4:0] ewr, input logic [63:0] ewd, input logic [31:0] epend);
        vec_t t;
        t.v0 = v0; t.r0 = r0; t.d0 = d0; t.v1 = v1; t.r1 = r1; t.d1 = d1;
        t.er0 = er0; t.er1 = er1; t.erw = erw; t.ewr = ewr; t.ewd = ewd; t.epend = epend;
        return t;
    endfunction

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] A3 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] A7 = 64'h7777_0000_0000_0007;

    vec_t tbl[7];

    initial begin
        logic a0, a1;
        int   k0, k1;

        // Single write, then two-way contention from a fresh reset.
        tbl[0] = mkv(1, 5, D1, 0, 0, 0,   1, 1, 0, 5'd0, 64'd0, 32'h0000_0020);
        tbl[1] = mkv(0, 0, 0,  0, 0, 0,   1, 1, 1, 5'd5, D1,    32'h0000_0020);
        tbl[2] = mkv(0, 0, 0,  0, 0, 0,   1, 1, 0, 5'd5, D1,    32'h0000_0000);
        tbl[3] = mkv(1, 3, A3, 1, 7, A7,  1, 1, 0, 5'd5, D1,    32'h0000_0088);
        tbl[4] = mkv(0, 0, 0,  0, 0, 0,   1, 0, 1, 5'd3, A3,    32'h0000_0088);
        tbl[5] = mkv(0, 0, 0,  0, 0, 0,   1, 1, 1, 5'd7, A7,    32'h0000_0080);
        tbl[6] = mkv(0, 0, 0,  0, 0, 0,   1, 1, 0, 5'd7, A7,    32'h0000_0000);

        idle();
        model_reset();
        reset = 1'b1;
        #2;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            req0_valid = tbl[i].v0; req0_reg = tbl[i].r0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_reg = tbl[i].r1; req1_data = tbl[i].d1;
            #1;
            chk("tbl_ready0", req0_ready, tbl[i].er0);
            chk("tbl_ready1", req1_ready, tbl[i].er1);
            @(posedge clk);
            #1;
            chk("tbl_regwrite", RegWrite, tbl[i].erw);
            chk("tbl_write_reg", WriteRegister, tbl[i].ewr);
            chk("tbl_write_data", WriteData, tbl[i].ewd);
            chk("tbl_pending", pending, tbl[i].epend);
        end

        // Continuous contention on distinct registers: strict alternation.
        do_reset();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 7; c++) begin
            req0_valid = 1'b1; req0_reg = 5'(1 + k0);  req0_data = {8'h00, 24'd0, 32'(k0)};
            req1_valid = 1'b1; req1_reg = 5'(16 + k1); req1_data = {8'h01, 24'd0, 32'(k1)};
            step(a0, a1);
            if (a0) k0++;
            if (a1) k1++;
            if (c >= 1) begin
                chk("contend_regwrite", RegWrite, 1'b1);
                chk("contend_order", WriteData[63:56], 64'((c - 1) % 2));
            end
        end
        idle();
        for (int c = 0; c < 4; c++) step(a0, a1);

        // Same register: the older req1 write must beat a younger req0 write
        // even though the round-robin pointer favours requester 0.
        do_reset();
        req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 64'hAAAA_0000_0000_0001;
        req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 64'hBBBB_0000_0000_0002;
        step(a0, a1);
        req0_data  = 64'hCCCC_0000_0000_0003;
        req1_valid = 1'b0;
        step(a0, a1);
        chk("same_reg_first", WriteData, 64'hAAAA_0000_0000_0001);
        idle();
        step(a0, a1);
        chk("same_reg_second", WriteData, 64'hBBBB_0000_0000_0002);
        step(a0, a1);
        chk("same_reg_third", WriteData, 64'hCCCC_0000_0000_0003);
        step(a0, a1);

        // X31 write is consumed but never enables the register file.
        do_reset();
        req0_valid = 1'b1; req0_reg = 5'd31; req0_data = 64'h3131_3131_3131_3131;
        step(a0, a1);
        chk("x31_pending", pending[31], 1'b0);
        idle();
        for (int c = 0; c < 3; c++) begin
            step(a0, a1);
            chk("x31_regwrite", RegWrite, 1'b0);
            chk("x31_pending", pending[31], 1'b0);
        end

        // Reset between acceptance and issue, and while RegWrite is high.
        do_reset();
        req1_valid = 1'b1; req1_reg = 5'd12; req1_data = 64'h1212_1212_1212_1212;
        step(a0, a1);
        idle();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(a0, a1);
            chk("rst_drop_regwrite", RegWrite, 1'b0);
        end
        req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 64'h0404_0404_0404_0404;
        step(a0, a1);
        idle();
        step(a0, a1);
        do_reset();
        step(a0, a1);

        // Random traffic over a small register set to provoke same-register
        // conflicts and X31 writes, with occasional asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            int t0, t1;
            t0 = int'($urandom_range(0, 4));
            t1 = int'($urandom_range(0, 4));
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_reg   = (t0 == 4) ? 5'd31 : 5'(t0);
            req1_reg   = (t1 == 4) ? 5'd31 : 5'(t1);
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            step(a0, a1);
            if ($urandom_range(0, 79) == 0) do_reset();
        end
        idle();
        for (int c = 0; c < 4; c++) step(a0, a1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
